// File: rtl/sl_tx_if.sv
// Router-side handshake and SL line bundle for one TX channel.
// The master modport is the router side and the slave modport is the channel.
interface sl_tx_if;
  logic [31:0] wr_data;
  logic        data_we;
  logic [15:0] wr_config;
  logic        config_we;
  logic        busy;
  logic [15:0] config_out;
  logic        status_changed;
  logic        sl0;
  logic        sl1;

  modport master (
    output wr_data, data_we, wr_config, config_we,
    input  busy, config_out, status_changed, sl0, sl1
  );

  modport slave (
    input  wr_data, data_we, wr_config, config_we,
    output busy, config_out, status_changed, sl0, sl1
  );
endinterface

// File: rtl/sl_tx_channel.sv
// Single SL-line transmitter channel.
// Serialises a 32-bit word LSB first onto the two-wire SL line.
// Both SL lines idle high.
// Optional odd parity is built only when SL_TX_PARITY_EN is defined.
// Without that macro, config[14] is stored and read back but has no effect.
//
// state | meaning
// IDLE  | waiting for data_we; config writes accepted
// PULSE | current bit driven low on sl0 (bit=0) or sl1 (bit=1) for D+1 cycles
// GAP   | both lines high for D+1 cycles between bits
// STOP  | inter-word idle gap of STOP_BITS*2*(D+1) cycles, still busy
module sl_tx_channel #(
  parameter int CONFIG_WIDTH = 16,
  parameter int STOP_BITS    = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  sl_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, STOP} state_t;

  state_t                  state;
  logic [CONFIG_WIDTH-1:0] cfg_q;
  logic [32:0]             sh;
  logic [5:0]              bits_left;
  logic [7:0]              d_q;
  logic [15:0]             cnt;
  logic                    busy_q;
  logic                    sc_q;
  logic                    sl0_q;
  logic                    sl1_q;

  logic [5:0]  l_raw;
  logic [5:0]  l_eff;
  logic [7:0]  d_eff;
  logic        par_en;
  logic        par_bit;
  logic [31:0] data_m;
  logic [32:0] frame;
  logic [5:0]  n_bits;
  logic [15:0] stop_len;

  // Effective word parameters; a config write in the same cycle as data_we applies to this word.
  always_comb begin
    l_raw = bus.config_we ? bus.wr_config[5:0] : cfg_q[5:0];
    d_eff = bus.config_we ? bus.wr_config[13:6] : cfg_q[13:6];
    if (l_raw < 6'd8)
      l_eff = 6'd8;
    else if (l_raw > 6'd32)
      l_eff = 6'd32;
    else
      l_eff = l_raw;
    for (int i = 0; i < 32; i++)
      data_m[i] = bus.wr_data[i] && (6'(i) < l_eff);
`ifdef SL_TX_PARITY_EN
    par_en  = bus.config_we ? bus.wr_config[14] : cfg_q[14];
    par_bit = ~(^data_m);
`else
    par_en  = 1'b0;
    par_bit = 1'b0;
`endif
    // The parity bit sits directly above the last data bit, so it is shifted out in order.
    frame    = {1'b0, data_m} | (33'(par_en & par_bit) << l_eff);
    n_bits   = l_eff + {5'd0, par_en};
    stop_len = 16'(STOP_BITS * 2 * (int'(d_q) + 1) - 1);
  end

  // Sequencer with registered line, busy and strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_q     <= '0;
      sh        <= '0;
      bits_left <= '0;
      d_q       <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      sc_q      <= 1'b0;
      sl0_q     <= 1'b1;
      sl1_q     <= 1'b1;
    end else begin
      sc_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.config_we)
            cfg_q <= bus.wr_config;
          if (bus.data_we) begin
            sh        <= frame;
            bits_left <= n_bits - 6'd1;
            d_q       <= d_eff;
            cnt       <= {8'd0, d_eff};
            state     <= PULSE;
            busy_q    <= 1'b1;
            sc_q      <= 1'b1;
            sl0_q     <= frame[0];
            sl1_q     <= ~frame[0];
          end
        end
        PULSE: begin
          if (cnt == 16'd0) begin
            sl0_q <= 1'b1;
            sl1_q <= 1'b1;
            cnt   <= {8'd0, d_q};
            state <= GAP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: begin
          if (cnt == 16'd0) begin
            if (bits_left != 6'd0) begin
              sh        <= sh >> 1;
              bits_left <= bits_left - 6'd1;
              cnt       <= {8'd0, d_q};
              state     <= PULSE;
              sl0_q     <= sh[1];
              sl1_q     <= ~sh[1];
            end else begin
              cnt   <= stop_len;
              state <= STOP;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (cnt == 16'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            sc_q   <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.config_out     = cfg_q;
  assign bus.status_changed = sc_q;
  assign bus.sl0            = sl0_q;
  assign bus.sl1            = sl1_q;

endmodule

// File: tb/tb_sl_tx_channel.sv
// Self-checking bench for sl_tx_channel.
// Directed cases and randomised words are compared against a per-cycle waveform model.
// The model computes the expected waveform from the bit period, bit list and stop gap.
module tb_sl_tx_channel;
  localparam int STOP_BITS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sl_tx_if bus ();

  sl_tx_channel #(.CONFIG_WIDTH(16), .STOP_BITS(STOP_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] cfg_m = 16'h0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [15:0] c);
    int l;
    l = int'(c[5:0]);
    if (l < 8) l = 8;
    if (l > 32) l = 32;
    return l;
  endfunction

  function automatic bit par_on(input logic [15:0] c);
`ifdef SL_TX_PARITY_EN
    return c[14];
`else
    return 1'b0;
`endif
  endfunction

  // Bit i of the transmitted sequence: data bits first, then odd parity.
  function automatic bit exp_bit(input logic [31:0] data, input logic [15:0] c, input int i);
    int          l;
    logic [31:0] m;
    l = eff_len(c);
    m = (l == 32) ? 32'hFFFF_FFFF : ((32'd1 << l) - 32'd1);
    if (i < l) return data[i];
    return ($countones(data & m) % 2) == 0;
  endfunction

  task automatic clear_inputs();
    bus.data_we   = 1'b0;
    bus.config_we = 1'b0;
    bus.wr_data   = 32'h0;
    bus.wr_config = 16'h0;
  endtask

  // Start at a negedge in IDLE; sends one word and checks the whole busy window.
  task automatic run_word(input logic [15:0] cfg, input bit do_cfg, input logic [31:0] data,
                          input bit inject, input string tag);
    logic [15:0] c;
    logic [63:0] bits_exp, bits_obs;
    int l, p, n, exp_len, k, mis, both, sc_cnt, npulse, bi, ph;
    bit done, prev_low, low, lowexp, e0, e1;
    c = do_cfg ? cfg : cfg_m;
    l = eff_len(c);
    p = int'(c[13:6]) + 1;
    n = l + (par_on(c) ? 1 : 0);
    exp_len = (n + STOP_BITS) * 2 * p;
    bits_exp = '0;
    bits_obs = '0;
    for (int i = 0; i < n; i++) bits_exp[i] = exp_bit(data, c, i);
    bus.wr_data   = data;
    bus.data_we   = 1'b1;
    bus.wr_config = cfg;
    bus.config_we = do_cfg;
    if (do_cfg) cfg_m = cfg;
    @(negedge clk);
    clear_inputs();
    k = 0; mis = 0; both = 0; sc_cnt = 0; npulse = 0;
    done = 1'b0; prev_low = 1'b0;
    for (int t = 0; t < 20000 && !done; t++) begin
      sc_cnt += int'(bus.status_changed);
      if (!bus.busy) begin
        done = 1'b1;
        if (bus.sl0 !== 1'b1 || bus.sl1 !== 1'b1) mis++;
      end else begin
        bi = k / (2 * p);
        ph = k % (2 * p);
        lowexp = (bi < n) && (ph < p);
        e0 = !(lowexp && !bits_exp[bi]);
        e1 = !(lowexp && bits_exp[bi]);
        if (bus.sl0 !== e0 || bus.sl1 !== e1) mis++;
        if (!bus.sl0 && !bus.sl1) both++;
        low = !bus.sl0 || !bus.sl1;
        if (low && !prev_low) begin
          if (npulse < 64) bits_obs[npulse] = !bus.sl1;
          npulse++;
        end
        prev_low = low;
        k++;
        if (inject && k == 3) begin
          bus.wr_data   = 32'h12;
          bus.data_we   = 1'b1;
          bus.wr_config = 16'hFFFF;
          bus.config_we = 1'b1;
        end else begin
          clear_inputs();
        end
        @(negedge clk);
      end
    end
    clear_inputs();
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy_len"}, k, exp_len);
    chk({tag, " wave_mis"}, mis, 0);
    chk({tag, " both_low"}, both, 0);
    chk({tag, " pulses"}, npulse, n);
    chk({tag, " bits"}, bits_obs, bits_exp);
    chk({tag, " sc_cnt"}, sc_cnt, 2);
    chk({tag, " cfg_out"}, bus.config_out, cfg_m);
  endtask

  initial begin
    logic [15:0] rc;
    int viol;
    int sc_cnt;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst busy", bus.busy, 1'b0);
    chk("rst sl0", bus.sl0, 1'b1);
    chk("rst sl1", bus.sl1, 1'b1);
    chk("rst cfg", bus.config_out, 16'h0000);
    chk("rst sc", bus.status_changed, 1'b0);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy || !bus.sl0 || !bus.sl1 || bus.status_changed || bus.config_out != 16'h0)
        viol++;
    end
    chk("idle viol", viol, 0);

    run_word(16'h0088, 1'b1, 32'h0000_00A5, 1'b0, "basic");
    run_word(16'h4088, 1'b1, 32'h0000_00A5, 1'b0, "parity");
    run_word(16'h0000, 1'b1, 32'h0000_00FF, 1'b0, "clamp_a");
    run_word(16'h0028, 1'b1, 32'h8000_0001, 1'b0, "clamp_b");
    run_word(16'h0088, 1'b1, 32'h0000_003C, 1'b1, "busy_wr");
    run_word(16'h0000, 1'b0, 32'h0000_005A, 1'b0, "keep_cfg");

    // Reset during the first pulse: lines and busy drop at once, no strobe.
    bus.wr_config = 16'h0088;
    bus.config_we = 1'b1;
    bus.wr_data   = 32'h0000_00C3;
    bus.data_we   = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst busy", bus.busy, 1'b0);
    chk("mid_rst sl0", bus.sl0, 1'b1);
    chk("mid_rst sl1", bus.sl1, 1'b1);
    chk("mid_rst sc", bus.status_changed, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_m = 16'h0000;
    chk("mid_rst cfg", bus.config_out, 16'h0000);
    sc_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      sc_cnt += int'(bus.status_changed);
    end
    chk("mid_rst no_sc", sc_cnt, 0);
    run_word(16'h0088, 1'b1, 32'h0000_0069, 1'b0, "post_rst");

    for (int w = 0; w < 12; w++) begin
      rc = 16'($urandom);
      rc[13:6] = 8'($urandom_range(0, 3));
      run_word(rc, ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 1) == 1), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
